// File: rtl/dcache_assoc.sv
// rtl/dcache_assoc.sv - set-associative write-through, no-write-allocate data cache
// Round-robin arbitration over LSU ports, per-set round-robin victim, saturating hit/miss counters.
module dcache_assoc #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_BLOCKS    = 8,
  parameter int NUM_WAYS      = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     controller_read_valid,
  output logic [ADDR_BITS-1:0]     controller_read_address,
  input  logic                     controller_read_ready,
  input  logic [DATA_BITS-1:0]     controller_read_data,
  output logic                     controller_write_valid,
  output logic [ADDR_BITS-1:0]     controller_write_address,
  output logic [DATA_BITS-1:0]     controller_write_data,
  input  logic                     controller_write_ready,
  output logic [CNT_BITS-1:0]      hit_count,
  output logic [CNT_BITS-1:0]      miss_count
);

  localparam int NUM_SETS = NUM_BLOCKS / NUM_WAYS;
  localparam int IDX_BITS = $clog2(NUM_SETS);
  localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
  localparam int TAG_BITS = ADDR_BITS - IDX_BITS;
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PORT_W   = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_READ, S_MEM_WRITE, S_RESPOND, S_RELEASE
  } state_t;

  state_t                    state_q;
  logic [PORT_W-1:0]         rr_ptr_q;
  logic [PORT_W-1:0]         port_q;
  logic                      op_write_q;
  logic [ADDR_BITS-1:0]      addr_q;
  logic [DATA_BITS-1:0]      wdata_q;
  logic [NUM_WAYS-1:0]       valid_q  [NUM_SETS];
  logic [WAY_W-1:0]          victim_q [NUM_SETS];
  logic [TAG_BITS-1:0]       tag_q    [NUM_SETS][NUM_WAYS];
  logic [DATA_BITS-1:0]      data_q   [NUM_SETS][NUM_WAYS];
  logic [CNT_BITS-1:0]       hit_cnt_q, miss_cnt_q;
  logic [NUM_CONSUMERS-1:0]  rd_ready_q, wr_ready_q;
  logic [DATA_BITS-1:0]      rd_data_q [NUM_CONSUMERS];
  logic                      ctrl_rd_valid_q, ctrl_wr_valid_q;
  logic [ADDR_BITS-1:0]      ctrl_rd_addr_q, ctrl_wr_addr_q;
  logic [DATA_BITS-1:0]      ctrl_wr_data_q;

  logic [IDX_W-1:0]          req_idx;
  logic [TAG_BITS-1:0]       req_tag;
  logic                      hit;
  logic [WAY_W-1:0]          hit_way;
  logic                      found_inv;
  logic [WAY_W-1:0]          victim_way;
  logic [NUM_CONSUMERS-1:0]  req_vec;
  logic                      grant_valid;
  logic [PORT_W-1:0]         grant_port;
  logic [PORT_W-1:0]         cand;
  int                        p;
  logic                      arr_we;
  logic [WAY_W-1:0]          arr_way;
  logic [DATA_BITS-1:0]      arr_wdata;

  // With a single set the mask forces index 0 and the whole address becomes the tag.
  assign req_idx = addr_q[IDX_W-1:0] & IDX_W'(NUM_SETS - 1);
  assign req_tag = addr_q[ADDR_BITS-1:IDX_BITS];
  assign req_vec = consumer_read_valid | consumer_write_valid;

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    found_inv  = 1'b0;
    victim_way = victim_q[req_idx];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!found_inv && !valid_q[req_idx][w]) begin
        found_inv  = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    cand        = '0;
    p           = 0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      p = int'(rr_ptr_q) + i;
      if (p >= NUM_CONSUMERS) p = p - NUM_CONSUMERS;
      cand = PORT_W'(p);
      if (!grant_valid && req_vec[cand]) begin
        grant_valid = 1'b1;
        grant_port  = cand;
      end
    end
  end

  always_comb begin
    arr_we    = 1'b0;
    arr_way   = hit_way;
    arr_wdata = wdata_q;
    if (state_q == S_LOOKUP && op_write_q && hit) begin
      arr_we = 1'b1;
    end else if (state_q == S_MEM_READ && controller_read_ready) begin
      arr_we    = 1'b1;
      arr_way   = victim_way;
      arr_wdata = controller_read_data;
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (arr_we) begin
      tag_q[req_idx][arr_way]  <= req_tag;
      data_q[req_idx][arr_way] <= arr_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      port_q          <= '0;
      op_write_q      <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      rd_ready_q      <= '0;
      wr_ready_q      <= '0;
      ctrl_rd_valid_q <= 1'b0;
      ctrl_wr_valid_q <= 1'b0;
      ctrl_rd_addr_q  <= '0;
      ctrl_wr_addr_q  <= '0;
      ctrl_wr_data_q  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
      end
      for (int c = 0; c < NUM_CONSUMERS; c++) rd_data_q[c] <= '0;
    end else begin
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            port_q     <= grant_port;
            op_write_q <= !consumer_read_valid[grant_port];
            addr_q     <= consumer_read_valid[grant_port] ? consumer_read_address[grant_port]
                                                          : consumer_write_address[grant_port];
            wdata_q    <= consumer_write_data[grant_port];
            rr_ptr_q   <= (grant_port == PORT_W'(NUM_CONSUMERS - 1)) ? '0 : grant_port + 1'b1;
            state_q    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (op_write_q) begin
            ctrl_wr_valid_q <= 1'b1;
            ctrl_wr_addr_q  <= addr_q;
            ctrl_wr_data_q  <= wdata_q;
            state_q         <= S_MEM_WRITE;
          end else if (hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            rd_data_q[port_q]  <= data_q[req_idx][hit_way];
            rd_ready_q[port_q] <= 1'b1;
            state_q            <= S_RESPOND;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            ctrl_rd_valid_q <= 1'b1;
            ctrl_rd_addr_q  <= addr_q;
            state_q         <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (controller_read_ready) begin
            ctrl_rd_valid_q              <= 1'b0;
            valid_q[req_idx][victim_way] <= 1'b1;
            if (!found_inv) begin
              victim_q[req_idx] <= (victim_way == WAY_W'(NUM_WAYS - 1)) ? '0 : victim_way + 1'b1;
            end
            rd_data_q[port_q]  <= controller_read_data;
            rd_ready_q[port_q] <= 1'b1;
            state_q            <= S_RESPOND;
          end
        end
        S_MEM_WRITE: begin
          if (controller_write_ready) begin
            ctrl_wr_valid_q    <= 1'b0;
            wr_ready_q[port_q] <= 1'b1;
            state_q            <= S_RESPOND;
          end
        end
        S_RESPOND: state_q <= S_RELEASE;
        S_RELEASE: begin
          // Hold off re-arbitration until the serviced request is withdrawn.
          if (op_write_q ? !consumer_write_valid[port_q] : !consumer_read_valid[port_q]) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign consumer_read_ready      = rd_ready_q;
  assign consumer_write_ready     = wr_ready_q;
  assign consumer_read_data       = rd_data_q;
  assign controller_read_valid    = ctrl_rd_valid_q;
  assign controller_read_address  = ctrl_rd_addr_q;
  assign controller_write_valid   = ctrl_wr_valid_q;
  assign controller_write_address = ctrl_wr_addr_q;
  assign controller_write_data    = ctrl_wr_data_q;
  assign hit_count                = hit_cnt_q;
  assign miss_count               = miss_cnt_q;

endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Set-associative, write-through, no-write-allocate data cache between the per-core LSU consumers and the global memory controller.
- Generalises the direct-mapped, pass-through data cache in four ways:
  - parametrised ways and sets;
  - round-robin arbitration across NUM_CONSUMERS;
  - a per-set round-robin victim pointer;
  - hit/miss performance counters.
- One request is serviced at a time; the block owns one controller channel.

Parameters:
ADDR_BITS, 8, address width
DATA_BITS, 8, word width; block size fixed at one word
NUM_CONSUMERS, 8, LSU ports
NUM_BLOCKS, 8, total lines; power of two
NUM_WAYS, 4, associativity; power of two, divides NUM_BLOCKS; NUM_SETS = NUM_BLOCKS/NUM_WAYS
CNT_BITS, 16, width of each perf counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
consumer_read_valid  in  NUM_CONSUMERS  per-port read request, held until ready
consumer_read_address  in  [NUM_CONSUMERS] x ADDR_BITS  read address
consumer_read_ready  out  NUM_CONSUMERS  one-cycle completion pulse
consumer_read_data  out  [NUM_CONSUMERS] x DATA_BITS  read data, valid with ready
consumer_write_valid  in  NUM_CONSUMERS  per-port write request, held until ready
consumer_write_address  in  [NUM_CONSUMERS] x ADDR_BITS  write address
consumer_write_data  in  [NUM_CONSUMERS] x DATA_BITS  write data
consumer_write_ready  out  NUM_CONSUMERS  one-cycle completion pulse
controller_read_valid  out  1  memory read request
controller_read_address  out  ADDR_BITS  memory read address
controller_read_ready  in  1  memory read done
controller_read_data  in  DATA_BITS  memory read data
controller_write_valid  out  1  memory write request
controller_write_address  out  ADDR_BITS  memory write address
controller_write_data  out  DATA_BITS  memory write data
controller_write_ready  in  1  memory write done
hit_count  out  CNT_BITS  saturating read-hit counter
miss_count  out  CNT_BITS  saturating read-miss counter

Behaviour:
- Reset (asynchronous, any state): the following are cleared.
  - FSM returns to IDLE.
  - All valid bits, victim pointers and counters clear.
  - All ready, valid, address and data outputs drive 0.
  - Tag and data arrays need no reset.
  - An in-flight controller request is abandoned.
- Address split:
  - index = addr[log2(NUM_SETS)-1:0]; tag = remaining upper bits.
  - When NUM_SETS = 1 the index is empty and the full address is the tag.
- Arbitration in IDLE:
  - A port requests if read_valid or write_valid is high.
  - The round-robin pointer starts at port 0. The first requester at or after the pointer is granted.
  - On grant, the pointer moves to granted+1, wrapping at NUM_CONSUMERS.
  - If a port raises both valids, the read is serviced first; the write is serviced on a later grant.
  - On grant, the block latches port id, op, address and write data into request registers.
- FSM states:
  - IDLE: grant → LOOKUP.
  - LOOKUP: compare the tag against all ways of the set.
    - Read hit: hit_count+1 → RESPOND, with data taken from the hitting way.
    - Read miss: miss_count+1 → MEM_READ.
    - Write, hit or miss: → MEM_WRITE. On a hit, the data array is updated in this cycle.
  - MEM_READ: controller_read_valid=1 with the latched address, held until controller_read_ready. On ready, write the line into the victim way and set its valid bit → RESPOND.
  - Victim selection: the lowest-numbered invalid way in the set. If all ways are valid, the way at the set's victim pointer is used and the pointer advances by 1 mod NUM_WAYS.
  - MEM_WRITE: controller_write_valid=1 with the latched address and data, held until controller_write_ready → RESPOND. A write miss does not allocate a line.
  - RESPOND: assert the granted port's read_ready or write_ready for exactly one cycle, with consumer_read_data driven in the same cycle → RELEASE.
  - RELEASE: wait until the granted port's serviced valid is low, then → IDLE. This prevents a double-service of the same request.
- Latency, counted from the first cycle the valid is sampled high in IDLE:
  - Read hit: ready in cycle +2.
  - Miss or write: ready one cycle after controller ready is sampled.
- Controller handshake:
  - Valid drops in the cycle after ready is sampled.
  - Address and data stay stable while valid is high.
- Counters saturate at all-ones and do not wrap.
- consumer_read_data for non-granted ports holds its last value.

Test Plan:
- Cold read: port 0 reads 0x13; memory returns 0xA5 after 3 cycles → a single controller read to 0x13; port 0 read_ready pulses once with 0xA5; miss_count=1.
- Re-read of 0x13 from port 5 → no controller activity; ready at +2 with 0xA5; hit_count=1.
- Write-through update: port 2 writes 0x5C to 0x13 → controller write (0x13, 0x5C); a subsequent read of 0x13 hits and returns 0x5C. Then a write to uncached 0x77 → controller write only; a following read of 0x77 misses.
- Associativity and replacement: NUM_SETS=2; read 0x00, 0x02, 0x04, 0x06 (all set 0), then 0x08 → the 0x08 fill evicts way 0; 0x02 still hits; 0x00 misses.
- Arbitration: ports 1, 3 and 6 assert reads in the same cycle → serviced in order 1, 3, 6; each ready pulses exactly once. Port 6 then re-requests with ports 1 and 3 still high → grant order 1, 3, 6 again.
- Reset mid-miss: assert reset while controller_read_valid=1 → all outputs 0 immediately; all lines invalid; counters 0; a subsequent read of a previously cached address misses.
